// File: rtl/i2c_pkg.sv
// Shared constants and the FSM state type for the I2C sensor target.
package i2c_pkg;

  localparam logic [6:0] SENSOR_ADDR = 7'h40;
  localparam logic [7:0] CMD_TEMP    = 8'hE3;
  localparam logic [7:0] CMD_HUMI    = 8'hE5;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    CMD,
    CMD_ACK,
    WAIT_RS,
    RADDR,
    RADDR_ACK,
    STRETCH,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_line_mon.sv
// Bus line monitor: 2-FF synchronizers, SCL edge detect, START/STOP detect.
module i2c_line_mon (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;
  logic       scl_s;

  // Synchronize both lines and keep one delayed copy for edge detection.
  // Flops reset high so leaving reset never looks like a falling SDA.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_sensor_target.sv
// I2C target emulating a temperature/humidity sensor with clock stretching.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in write address byte
// ADDR_ACK  | acknowledging write address
// CMD       | shifting in command byte
// CMD_ACK   | acknowledging supported command
// WAIT_RS   | waiting for repeated START
// RADDR     | shifting in read address byte
// RADDR_ACK | acknowledging read address
// STRETCH   | holding SCL low, then loading the data word
// TX        | shifting out data bits
// TX_ACK    | sampling master ACK/NACK after byte 1
// WAIT_STOP | ignoring the bus until STOP
module i2c_sensor_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR      = SENSOR_ADDR,
  parameter int         STRETCH_TICKS = 45_455,
  parameter int         HOLD_TICKS    = 2
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         SCL,
  inout  wire         SDA,
  input  logic [15:0] temp_data,
  input  logic [15:0] humi_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic        busy,
  output logic        proto_err
);

  localparam int SW = (STRETCH_TICKS < 2) ? 1 : $clog2(STRETCH_TICKS + 1);
  localparam int HW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [SW-1:0] STRETCH_INIT = SW'(STRETCH_TICKS);
  localparam logic [SW-1:0] STRETCH_ONE  = SW'(1);
  localparam logic [HW-1:0] HOLD_INIT    = HW'(HOLD_TICKS);

  state_t        state;
  logic          scl_low;
  logic          sda_low;
  logic [3:0]    bit_cnt;
  logic [6:0]    rx_sr;
  logic [14:0]   tx_sr;
  logic [HW-1:0] hold_cnt;
  logic          hold_pend;
  logic [1:0]    ack_phase;
  logic          byte2;
  logic          ack_seen;
  logic [SW-1:0] stretch_cnt;

  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;
  logic [7:0]    rx_byte;
  logic          hold_done;
  logic [15:0]   sel_data;

  assign SCL = scl_low ? 1'b0 : 1'bz;
  assign SDA = sda_low ? 1'b0 : 1'bz;

  i2c_line_mon u_line_mon (
    .clk       (clk),
    .rst       (rst),
    .scl       (SCL),
    .sda       (SDA),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte   = {rx_sr, sda_s};
  assign hold_done = hold_pend && (hold_cnt == '0);
  assign sel_data  = (cmd == CMD_HUMI) ? humi_data : temp_data;

  // Target protocol FSM; START/STOP override every state, START wins over SCL edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scl_low     <= 1'b0;
      sda_low     <= 1'b0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      hold_cnt    <= '0;
      hold_pend   <= 1'b0;
      ack_phase   <= '0;
      byte2       <= 1'b0;
      ack_seen    <= 1'b0;
      stretch_cnt <= '0;
      cmd         <= 8'h00;
      cmd_valid   <= 1'b0;
      busy        <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      proto_err <= 1'b0;
      if (hold_pend && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;

      if (start_det) begin
        state     <= (state == WAIT_RS) ? RADDR : ADDR;
        busy      <= 1'b1;
        bit_cnt   <= '0;
        sda_low   <= 1'b0;
        scl_low   <= 1'b0;
        hold_pend <= 1'b0;
        ack_phase <= '0;
        byte2     <= 1'b0;
        ack_seen  <= 1'b0;
      end else if (stop_det) begin
        if (!(state inside {IDLE, WAIT_STOP, WAIT_RS})) proto_err <= 1'b1;
        state     <= IDLE;
        busy      <= 1'b0;
        sda_low   <= 1'b0;
        scl_low   <= 1'b0;
        hold_pend <= 1'b0;
        ack_phase <= '0;
      end else begin
        case (state)
          IDLE, WAIT_RS, WAIT_STOP: ;

          ADDR: if (scl_rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= '0;
              ack_phase <= '0;
              state     <= (rx_byte == {I2C_ADDR, 1'b0}) ? ADDR_ACK : WAIT_STOP;
            end
          end

          CMD: if (scl_rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= '0;
              ack_phase <= '0;
              if (rx_byte == CMD_TEMP || rx_byte == CMD_HUMI) begin
                cmd       <= rx_byte;
                cmd_valid <= 1'b1;
                state     <= CMD_ACK;
              end else begin
                proto_err <= 1'b1;
                state     <= WAIT_STOP;
              end
            end
          end

          RADDR: if (scl_rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= '0;
              ack_phase <= '0;
              state     <= (rx_byte == {I2C_ADDR, 1'b1}) ? RADDR_ACK : WAIT_STOP;
            end
          end

          // Phases: 0 wait fall, 1 hold then pull SDA, 2 wait fall, 3 hold then release.
          ADDR_ACK, CMD_ACK, RADDR_ACK: begin
            case (ack_phase)
              2'd0: if (scl_fall) begin
                hold_cnt  <= HOLD_INIT;
                hold_pend <= 1'b1;
                ack_phase <= 2'd1;
              end
              2'd1: if (hold_done) begin
                hold_pend <= 1'b0;
                sda_low   <= 1'b1;
                ack_phase <= 2'd2;
              end
              2'd2: if (scl_fall) begin
                hold_cnt  <= HOLD_INIT;
                hold_pend <= 1'b1;
                if (state == RADDR_ACK) begin
                  state       <= STRETCH;
                  scl_low     <= 1'b1;
                  stretch_cnt <= STRETCH_INIT;
                  ack_phase   <= 2'd0;
                end else begin
                  ack_phase <= 2'd3;
                end
              end
              default: if (hold_done) begin
                hold_pend <= 1'b0;
                sda_low   <= 1'b0;
                ack_phase <= 2'd0;
                state     <= (state == ADDR_ACK) ? CMD : WAIT_RS;
              end
            endcase
          end

          // ACK release runs off the hold counter; the first data bit is
          // placed on SDA one cycle before SCL is let go.
          STRETCH: begin
            if (hold_done) begin
              hold_pend <= 1'b0;
              sda_low   <= 1'b0;
            end
            if (stretch_cnt > STRETCH_ONE) begin
              stretch_cnt <= stretch_cnt - 1'b1;
            end else if (stretch_cnt == STRETCH_ONE) begin
              stretch_cnt <= '0;
              hold_pend   <= 1'b0;
              tx_sr       <= sel_data[14:0];
              sda_low     <= ~sel_data[15];
            end else begin
              scl_low <= 1'b0;
              bit_cnt <= '0;
              state   <= TX;
            end
          end

          TX: begin
            if (scl_rise) bit_cnt <= bit_cnt + 1'b1;
            if (scl_fall) begin
              hold_cnt  <= HOLD_INIT;
              hold_pend <= 1'b1;
            end else if (hold_done) begin
              hold_pend <= 1'b0;
              if (bit_cnt == 4'd8) begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
                state   <= byte2 ? WAIT_STOP : TX_ACK;
              end else begin
                sda_low <= ~tx_sr[14];
                tx_sr   <= {tx_sr[13:0], 1'b0};
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (sda_s) state <= WAIT_STOP;
              else       ack_seen <= 1'b1;
            end else if (scl_fall && ack_seen) begin
              hold_cnt  <= HOLD_INIT;
              hold_pend <= 1'b1;
            end else if (hold_done) begin
              hold_pend <= 1'b0;
              ack_seen  <= 1'b0;
              byte2     <= 1'b1;
              bit_cnt   <= '0;
              sda_low   <= ~tx_sr[14];
              tx_sr     <= {tx_sr[13:0], 1'b0};
              state     <= TX;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_sensor_target.md
I2C_SENSOR_TARGET -- requirements
Module: i2c_sensor_target

Interface
REQ-001 Parameter I2C_ADDR, default 7'h40, 7-bit target address.
REQ-002 Parameter STRETCH_TICKS, default 45_455, clk cycles SCL is held low after the read address ACK (1 ms at 22 ns).
REQ-003 Parameter HOLD_TICKS, default 2, clk cycles after a sampled SCL fall before SDA may change.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 SCL  inout  1  open-drain; driven 0 only during stretch, otherwise 'z.
REQ-007 SDA  inout  1  open-drain; driven 0 or 'z, never 1.
REQ-008 temp_data  input  16  temperature word returned for command 8'hE3.
REQ-009 humi_data  input  16  humidity word returned for command 8'hE5.
REQ-010 cmd_valid  output  1  one-cycle pulse when a supported command byte is ACKed.
REQ-011 cmd  output  8  last accepted command; valid from the cmd_valid pulse onward.
REQ-012 busy  output  1  high from START detect to STOP detect.
REQ-013 proto_err  output  1  one-cycle pulse on an unsupported command or a STOP before the transfer completes.

Function
REQ-014 SCL and SDA SHALL pass through 2-FF synchronizers; all edge and condition detection uses the synchronized values.
REQ-015 START: SDA falls while SCL high; STOP: SDA rises while SCL high; both are detected in every state.
REQ-016 Received bits SHALL be sampled on the synchronized SCL rising edge, MSB first.
REQ-017 States: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WAIT_RS, RADDR, RADDR_ACK, STRETCH, TX, TX_ACK, WAIT_STOP.
REQ-018 A START from any state SHALL go to ADDR with the bit counter cleared; a repeated START in WAIT_RS SHALL go to RADDR.
REQ-019 ADDR: after 8 bits, {I2C_ADDR,0} SHALL go to ADDR_ACK; any other value SHALL go to WAIT_STOP with SDA released.
REQ-020 ACK: after the SCL fall following bit 8 plus HOLD_TICKS, drive SDA 0 for one SCL high period, then release HOLD_TICKS after the next SCL fall.
REQ-021 CMD: 8'hE3 or 8'hE5 SHALL be ACKed and latched to cmd with a cmd_valid pulse; any other value SHALL be NACKed with a proto_err pulse, then go to WAIT_STOP.
REQ-022 RADDR: {I2C_ADDR,1} SHALL be ACKed; after the ACK SCL falls, go to STRETCH.
REQ-023 STRETCH: drive SCL low for STRETCH_TICKS cycles, latch temp_data or humi_data (selected by cmd) into the shift register, then release SCL.
REQ-024 TX: drive SDA bits MSB first, each updated HOLD_TICKS after an SCL fall; a 1 bit is 'z.
REQ-025 TX_ACK: after byte 1, master ACK (SDA 0) SHALL continue with byte 2; master NACK SHALL go to WAIT_STOP.
REQ-026 After byte 2, any master response SHALL go to WAIT_STOP; SDA SHALL stay released until STOP.
REQ-027 A STOP in IDLE, WAIT_STOP or WAIT_RS, or after byte 2, is normal; a STOP in any other state SHALL pulse proto_err; every STOP SHALL return to IDLE with SCL and SDA released.
REQ-028 A START and a STOP on the same cycle are impossible; if an SCL edge and a START occur together, the START has priority.
REQ-029 The stretch and hold counters SHALL saturate and must not wrap.

Reset
REQ-030 rst SHALL give state IDLE, SCL and SDA 'z, cmd 8'h00, and cmd_valid, busy, proto_err 0; it overrides mid-transfer, including during STRETCH.
REQ-031 The synchronizer flops SHALL reset to 1 so that reset causes no false START.

Structure
REQ-032 Package i2c_pkg SHALL hold the SENSOR_ADDR, CMD_TEMP and CMD_HUMI constants and the target state enum.
REQ-033 Sub-module i2c_line_mon SHALL do synchronization, SCL rise/fall detection and START/STOP detection.

Verification
REQ-034 With the team's i2c_master as initiator and temp_data=16'h6A3C: the temperature read returns 16'h6A3C, cmd_valid pulses once, and cmd=8'hE3.
REQ-035 Next cycle with humi_data=16'h8F10: the bench receives 16'h8F10, and SCL is low at least STRETCH_TICKS after the read-address ACK.
REQ-036 Address 7'h41 write: SDA is never driven, there is no cmd_valid, and busy falls at STOP.
REQ-037 Command 8'hF3: NACK on bit 9 and one proto_err pulse.
REQ-038 rst asserted during STRETCH: SCL is released on the next cycle and the state is IDLE; the next full transfer succeeds.
REQ-039 Master NACK after byte 1: SDA is released, and the STOP returns to IDLE with no proto_err.
